sdf_delay_line: RTL and testbench
=================================

// Module: sdf_delay_line
// PURPOSE
//  Parametrised complex delay line for the single-path delay-feedback (SDF) FFT stages; supersedes fixed SR_64.
//  Delays a valid-qualified complex (re/im) sample stream by exactly DEPTH accepted samples.
//  DEPTH is runtime-selectable up to MAX_DEPTH, so one instance serves every stage (N/2, N/4, ... 1).
//  Storage is a circular buffer with a wrapping pointer; there is no shift chain, so it maps to RAM/LUTRAM.
// PARAMETERS
//  DATA_W    16  width of each of re and im, two's complement
//  MAX_DEPTH 64  maximum delay in samples; power of two, >= 2
//  DEP_W     $clog2(MAX_DEPTH)+1  width of depth_sel (derived localparam)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       reset, synchronous, active-low
//  in_valid   in   1       accept in_re/in_im this cycle
//  in_re      in   DATA_W  input real part (signed)
//  in_im      in   DATA_W  input imaginary part (signed)
//  depth_sel  in   DEP_W   requested delay in samples
//  flush      in   1       synchronous clear of pointer/fill state (memory contents untouched)
//  out_valid  out  1       out_re/out_im hold a delayed sample this cycle
//  out_re     out  DATA_W  delayed real part
//  out_im     out  DATA_W  delayed imaginary part
//  filled     out  1       high once DEPTH samples accepted since last clear
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): ptr=0, fill_cnt=0, filled=0, out_valid=0, out_re=out_im=0, depth_q=clamp(depth_sel).
//  - Clamp: depth_eff = 1 if depth_sel==0; MAX_DEPTH if depth_sel>MAX_DEPTH; otherwise depth_sel.
//  - Accepted sample (in_valid=1, no clear), on the same edge:
//      out <= mem[ptr]; mem[ptr] <= in; ptr <= (ptr==depth_q-1) ? 0 : ptr+1.
//    This is a read-before-write at the same address.
//  - fill_cnt increments per accepted sample and saturates at depth_q; filled = (fill_cnt==depth_q).
//  - out_valid <= in_valid & filled (filled value before the edge). It is a one-cycle pulse per accepted sample.
//  - out_re/out_im hold their value when in_valid=0. Valid gaps do not advance the delay.
//  - Latency: the k-th accepted sample (k from 0) appears on out one edge after the (k+DEPTH)-th sample is accepted.
//  - Clear condition = flush=1 OR clamp(depth_sel) != depth_q.
//    On clear: ptr=0, fill_cnt=0, filled=0, out_valid=0, depth_q<=clamp(depth_sel). A simultaneous in_valid sample is discarded.
//    Old memory contents are never emitted after a clear; the filled gating guarantees this.
//  - depth_q==1: out is the previous accepted sample (ptr stays 0).
//  - Wrap-around at depth_q-1 is independent of MAX_DEPTH; entries above depth_q are unused.
//  - Reset mid-stream behaves as clear and also zeroes out_re/out_im.
//  - No arithmetic on data; bit-exact pass-through, sign preserved.
// CONFIGURATION
//  SDF_DELAY_OREG_EN defined:
//    - Extra output register stage after the memory read.
//    - out_valid/out_re/out_im are delayed one further clk; latency becomes DEPTH samples + 2 edges.
//    - Clear and reset also zero the extra stage.
//  SDF_DELAY_OREG_EN undefined: behaviour exactly as above, with no extra stage.
// TESTING
//  T1 ramp: depth_sel=64, in_valid=1 continuous, in_re=0,1,2..., in_im=-in_re.
//     -> out_valid first high after the edge accepting re=64; out_re=0, out_im=0, then 1/-1, 2/-2...
//  T2 gaps: depth_sel=4, in_valid pattern 1,0,1,1,0,0,1,1,1 with re=10,11,12,...
//     -> outputs re=10,11,12... only on pulses following the 5th, 6th, ... accepted samples.
//  T3 depth change: run depth 8 to filled, then switch depth_sel=2.
//     -> out_valid=0 and filled=0 immediately; first output is the first post-change sample, 2 samples later.
//  T4 clamp/boundary: depth_sel=0 -> 1-sample delay; depth_sel=100 -> 64-sample delay;
//     fill across ptr wrap checked for 200 samples.
//  T5 flush and reset mid-stream at depth 16: flush with in_valid=1 -> that sample dropped, 16 new samples before out_valid.
//     rst_n=0 -> out_re=out_im=0, out_valid=0.
//  T6 rerun T1 and T2 with SDF_DELAY_OREG_EN -> identical data sequence, every out_valid one clk later.

Source files
------------

// File: rtl/sdf_delay_line.sv
// sdf_delay_line
//   Complex (re/im) delay line for the SDF FFT stages. A valid-qualified
//   sample stream is delayed by exactly depth accepted samples, where the
//   depth is selected at run time (1..MAX_DEPTH). Storage is a circular
//   buffer addressed by a wrapping pointer, so the array maps onto RAM.
//
//   Optional build macro: SDF_DELAY_OREG_EN adds one output register stage
//   after the memory read. Outputs then arrive one clk later, and a clear or
//   a reset zeroes that stage.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       synchronous active-low reset
//   in_valid   in   1       accept in_re/in_im this cycle
//   in_re      in   DATA_W  input real part (signed)
//   in_im      in   DATA_W  input imaginary part (signed)
//   depth_sel  in   DEP_W   requested delay in samples (0 -> 1, >MAX -> MAX)
//   flush      in   1       clear pointer/fill state, memory untouched
//   out_valid  out  1       one-cycle pulse: out_re/out_im hold a delayed sample
//   out_re     out  DATA_W  delayed real part
//   out_im     out  DATA_W  delayed imaginary part
//   filled     out  1       depth samples accepted since the last clear
//
// Handshake: in_valid has no backpressure; a sample is taken on every edge
// where in_valid=1 unless that same edge performs a clear. out_valid is a
// single-cycle qualifier with no ready; the consumer must take it then.
module sdf_delay_line #(
    parameter  int DATA_W    = 16,
    parameter  int MAX_DEPTH = 64,
    localparam int DEP_W     = $clog2(MAX_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic [DEP_W-1:0]  depth_sel,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              filled
);

    localparam int PTR_W = $clog2(MAX_DEPTH);
    localparam int WORD_W = 2 * DATA_W;

    logic [WORD_W-1:0] mem [MAX_DEPTH];

    logic [DEP_W-1:0]  depth_q;
    logic [DEP_W-1:0]  depth_eff;
    logic [DEP_W-1:0]  fill_cnt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_last;
    logic              clr;
    logic              accept;

    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;

    // Selected depth forced into the legal range 1..MAX_DEPTH.
    always_comb begin
        depth_eff = depth_sel;
        if (depth_sel == '0) begin
            depth_eff = DEP_W'(1);
        end else if (depth_sel > DEP_W'(MAX_DEPTH)) begin
            depth_eff = DEP_W'(MAX_DEPTH);
        end
    end

    // A changed depth restarts the line exactly like flush does, so samples
    // written under the old wrap point are never read back.
    assign clr      = flush | (depth_eff != depth_q);
    assign accept   = in_valid & ~clr;
    assign filled   = (fill_cnt == depth_q);
    // depth_q is always 1..MAX_DEPTH, so depth_q-1 fits in the pointer width.
    assign ptr_last = PTR_W'(depth_q - DEP_W'(1));

    // Memory write kept in its own process without reset so it infers RAM.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem[ptr] <= {in_re, in_im};
        end
    end

    // Synchronous read of the oldest entry before it is overwritten at the
    // same address on the same edge (read-before-write).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (accept) begin
            rd_data <= mem[ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ptr      <= '0;
            fill_cnt <= '0;
            rd_valid <= 1'b0;
            depth_q  <= depth_eff;
        end else begin
            // filled here is the pre-edge value: the entry being read is only
            // meaningful once depth samples have been written since the clear.
            rd_valid <= in_valid & filled;
            if (accept) begin
                ptr <= (ptr == ptr_last) ? '0 : ptr + PTR_W'(1);
                if (fill_cnt != depth_q) begin
                    fill_cnt <= fill_cnt + DEP_W'(1);
                end
            end
        end
    end

`ifdef SDF_DELAY_OREG_EN
    logic              oreg_valid;
    logic [WORD_W-1:0] oreg_data;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            oreg_valid <= 1'b0;
            oreg_data  <= '0;
        end else begin
            oreg_valid <= rd_valid;
            if (rd_valid) begin
                oreg_data <= rd_data;
            end
        end
    end

    assign out_valid = oreg_valid;
    assign out_re    = oreg_data[WORD_W-1:DATA_W];
    assign out_im    = oreg_data[DATA_W-1:0];
`else
    assign out_valid = rd_valid;
    assign out_re    = rd_data[WORD_W-1:DATA_W];
    assign out_im    = rd_data[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_sdf_delay_line.sv
module tb_sdf_delay_line;

  localparam int DATA_W    = 16;
  localparam int MAX_DEPTH = 64;
  localparam int DEP_W     = $clog2(MAX_DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic [DEP_W-1:0]  depth_sel;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic              filled;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sdf_delay_line #(.DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_re(in_re),
    .in_im(in_im),
    .depth_sel(depth_sel),
    .flush(flush),
    .out_valid(out_valid),
    .out_re(out_re),
    .out_im(out_im),
    .filled(filled)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  // Samples accepted since the last clear, oldest first.
  logic [2*DATA_W-1:0] exp_q[$];
  int                  m_depth = 0;
  bit                  m_s1_valid = 0;
  logic [2*DATA_W-1:0] m_s1_data = '0;
  bit                  m_s2_valid = 0;
  logic [2*DATA_W-1:0] m_s2_data = '0;
  bit                  m_filled = 0;

  bit pat[9] = '{1, 0, 1, 1, 0, 0, 1, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int d);
    if (d == 0) return 1;
    if (d > MAX_DEPTH) return MAX_DEPTH;
    return d;
  endfunction

  // Reference: a delay of D means an accepted sample leaves when the D-th
  // later sample arrives, i.e. whenever the history grows beyond D entries.
  task automatic model_step();
    int ce;
    bit s1v_prev;
    logic [2*DATA_W-1:0] s1d_prev;
    s1v_prev = m_s1_valid;
    s1d_prev = m_s1_data;
    ce = clamp(int'(depth_sel));
    if (!rst_n) begin
      exp_q.delete();
      m_depth    = ce;
      m_s1_valid = 0;
      m_s1_data  = '0;
      m_s2_valid = 0;
      m_s2_data  = '0;
    end else if (flush || ce != m_depth) begin
      exp_q.delete();
      m_depth    = ce;
      m_s1_valid = 0;
      m_s2_valid = 0;
      m_s2_data  = '0;
    end else begin
      m_s2_valid = s1v_prev;
      if (s1v_prev) m_s2_data = s1d_prev;
      m_s1_valid = 0;
      if (in_valid) begin
        exp_q.push_back({in_re, in_im});
        if (exp_q.size() > m_depth) begin
          m_s1_data  = exp_q.pop_front();
          m_s1_valid = 1;
        end
      end
    end
    m_filled = (exp_q.size() == m_depth);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    bit                  ev;
    logic [2*DATA_W-1:0] ed;
    @(negedge clk);
    if (chk_en) begin
`ifdef SDF_DELAY_OREG_EN
      ev = m_s2_valid;
      ed = m_s2_data;
`else
      ev = m_s1_valid;
      ed = m_s1_data;
`endif
      check("out_valid", 32'(out_valid), 32'(ev));
      check("filled", 32'(filled), 32'(m_filled));
      if (ev) begin
        check("out_re", 32'(out_re), 32'(ed[2*DATA_W-1:DATA_W]));
        check("out_im", 32'(out_im), 32'(ed[DATA_W-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
    in_valid = v;
    in_re    = re;
    in_im    = im;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_samples(input int n);
    for (int i = 0; i < n; i++) begin
      step(($urandom_range(0, 9) < 7), DATA_W'($urandom_range(0, 65535)),
           DATA_W'($urandom_range(0, 65535)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int re_v;
    int acc;
    rst_n     = 1'b0;
    flush     = 1'b0;
    depth_sel = DEP_W'(64);
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;

    step(0, 0, 0);
    chk_en = 1;
    step(1, 16'h1234, 16'h5678);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_re", 32'(out_re), 32'd0);
    check("rst_out_im", 32'(out_im), 32'd0);
    check("rst_filled", 32'(filled), 32'd0);
    rst_n = 1'b1;

    // T1 ramp at depth 64, across several pointer wraps.
    for (int i = 0; i < 64; i++) step(1, DATA_W'(i), DATA_W'(-i));
    check("t1_filled", 32'(m_filled), 32'd1);
    check("t1_no_out_yet", 32'(m_s1_valid), 32'd0);
    step(1, DATA_W'(64), DATA_W'(-64));
    check("t1_first_valid", 32'(m_s1_valid), 32'd1);
    check("t1_first_re", 32'(m_s1_data[31:16]), 32'h0000);
    check("t1_first_im", 32'(m_s1_data[15:0]), 32'h0000);
    step(1, DATA_W'(65), DATA_W'(-65));
    check("t1_second_re", 32'(m_s1_data[31:16]), 32'h0001);
    check("t1_second_im", 32'(m_s1_data[15:0]), 32'hffff);
    for (int i = 66; i < 200; i++) step(1, DATA_W'(i), DATA_W'(-i));
    check("t1_last_re", 32'(m_s1_data[31:16]), 32'd135);

    // T2 gaps at depth 4.
    depth_sel = DEP_W'(4);
    step(0, 0, 0);
    re_v = 10;
    acc  = 0;
    for (int i = 0; i < 9; i++) begin
      step(pat[i], DATA_W'(re_v), DATA_W'(-re_v));
      if (pat[i]) begin
        acc++;
        if (acc == 4) check("t2_no_out_4th", 32'(m_s1_valid), 32'd0);
        if (acc == 5) check("t2_out_5th", 32'(m_s1_data[31:16]), 32'd10);
        re_v++;
      end
    end
    check("t2_out_6th", 32'(m_s1_data[31:16]), 32'd11);

    // T3 depth change 8 -> 2 after filling.
    depth_sel = DEP_W'(8);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, DATA_W'(20 + i), 0);
    check("t3_filled8", 32'(filled), 32'd1);
    depth_sel = DEP_W'(2);
    step(1, DATA_W'(99), 0);
    check("t3_chg_filled", 32'(filled), 32'd0);
    check("t3_chg_valid", 32'(out_valid), 32'd0);
    step(1, DATA_W'(100), 0);
    step(1, DATA_W'(101), 0);
    check("t3_no_out", 32'(m_s1_valid), 32'd0);
    step(1, DATA_W'(102), 0);
    check("t3_first_re", 32'(m_s1_data[31:16]), 32'd100);

    // T4 clamp boundaries.
    depth_sel = DEP_W'(0);
    step(0, 0, 0);
    step(1, DATA_W'(7), 0);
    step(1, DATA_W'(8), 0);
    check("t4_depth0_re", 32'(m_s1_data[31:16]), 32'd7);
    rand_samples(20);
    depth_sel = DEP_W'(100);
    step(0, 0, 0);
    for (int i = 0; i < 64; i++) step(1, DATA_W'(300 + i), 0);
    check("t4_clamp_no_out", 32'(m_s1_valid), 32'd0);
    step(1, DATA_W'(364), 0);
    check("t4_clamp_re", 32'(m_s1_data[31:16]), 32'd300);
    rand_samples(200);

    // T5 flush and reset mid-stream at depth 16.
    depth_sel = DEP_W'(16);
    step(0, 0, 0);
    rand_samples(30);
    flush = 1'b1;
    step(1, DATA_W'(500), 0);
    flush = 1'b0;
    check("t5_flush_filled", 32'(filled), 32'd0);
    for (int i = 1; i <= 16; i++) step(1, DATA_W'(500 + i), 0);
    check("t5_no_out", 32'(m_s1_valid), 32'd0);
    step(1, DATA_W'(517), 0);
    check("t5_first_re", 32'(m_s1_data[31:16]), 32'd501);
    rand_samples(10);
    rst_n = 1'b0;
    step(1, DATA_W'(600), 0);
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_re", 32'(out_re), 32'd0);
    check("t5_rst_im", 32'(out_im), 32'd0);
    rst_n = 1'b1;

    // Random soak: random valid, occasional flush and depth changes.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) depth_sel = DEP_W'($urandom_range(0, 20));
      if ($urandom_range(0, 499) == 0) depth_sel = DEP_W'($urandom_range(0, 127));
      flush = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 9) < 7), DATA_W'($urandom_range(0, 65535)),
           DATA_W'($urandom_range(0, 65535)));
    end
    flush = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
